// File: rtl/ysyx_25020047_idu_pkg.sv
// Shared decode constants for the IDU: opcode/funct fields, the one-hot
// instruction-type layout and the per-format register-use encoding.
package ysyx_25020047_idu_pkg;

    // Major opcodes
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // funct3 values
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_D    = 3'b011;
    localparam logic [2:0] F3_BU   = 3'b100;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    // Bit positions inside the one-hot type vector; ILLEGAL has its own bit.
    typedef enum logic [4:0] {
        T_LUI, T_AUIPC, T_JAL, T_JALR, T_BEQ, T_BNE, T_LW, T_LBU, T_SW, T_SB,
        T_ADDI, T_SLTI, T_SLTIU, T_ADD, T_SUB, T_SLT, T_SLTU, T_XOR, T_EBREAK,
        T_LD, T_SD, T_ADDIW, T_ADDW, T_SUBW, T_ILLEGAL
    } type_idx_e;

    localparam int TYPE_W = int'(T_ILLEGAL) + 1;

    // Encoding formats; FMT_N carries no register and no immediate.
    typedef enum logic [2:0] {
        FMT_N, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

    // Register-use flags implied by a format.
    typedef struct packed {
        logic rs1;
        logic rs2;
        logic rd;
    } use_t;

    function automatic use_t fmt_use(input fmt_e f);
        use_t u;
        u.rs1 = f inside {FMT_R, FMT_I, FMT_S, FMT_B};
        u.rs2 = f inside {FMT_R, FMT_S, FMT_B};
        u.rd  = f inside {FMT_R, FMT_I, FMT_U, FMT_J};
        return u;
    endfunction

endpackage

// File: rtl/ysyx_25020047_idu_dec.sv
// Combinational instruction decoder: one-hot type, sign-extended immediate,
// register indices, register-use flags, rd write enable and illegal flag.
module ysyx_25020047_idu_dec
    import ysyx_25020047_idu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NR_REG = 32,
    localparam int AW    = $clog2(NR_REG)
) (
    input  logic [31:0]       inst_i,
    output logic [TYPE_W-1:0] type_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [AW-1:0]     rs1_o,
    output logic [AW-1:0]     rs2_o,
    output logic [AW-1:0]     rd_o,
    output logic              use_rs1_o,
    output logic              use_rs2_o,
    output logic              rd_wen_o,
    output logic              illegal_o
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1_f;
    logic [4:0]  rs2_f;
    logic [4:0]  rd_f;
    type_idx_e   idx;
    fmt_e        fmt;
    use_t        use_f;
    logic        bad_reg;
    logic        illegal;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm32;
    logic [XLEN-1:0] imm_sx;

    assign opcode = inst_i[6:0];
    assign f3     = inst_i[14:12];
    assign f7     = inst_i[31:25];
    assign rs1_f  = inst_i[19:15];
    assign rs2_f  = inst_i[24:20];
    assign rd_f   = inst_i[11:7];

    // Classify the instruction into a type index and an encoding format
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        idx = T_ILLEGAL;
        fmt = FMT_N;
        case (opcode)
            OP_LUI:   begin idx = T_LUI;   fmt = FMT_U; end
            OP_AUIPC: begin idx = T_AUIPC; fmt = FMT_U; end
            OP_JAL:   begin idx = T_JAL;   fmt = FMT_J; end
            OP_JALR: begin
                if (f3 == F3_ADD) begin idx = T_JALR; fmt = FMT_I; end
            end
            OP_BRANCH: begin
                if (f3 == F3_BEQ)      begin idx = T_BEQ; fmt = FMT_B; end
                else if (f3 == F3_BNE) begin idx = T_BNE; fmt = FMT_B; end
            end
            OP_LOAD: begin
                if (f3 == F3_W)              begin idx = T_LW;  fmt = FMT_I; end
                else if (f3 == F3_BU)        begin idx = T_LBU; fmt = FMT_I; end
                else if (RV64 && f3 == F3_D) begin idx = T_LD;  fmt = FMT_I; end
            end
            OP_STORE: begin
                if (f3 == F3_W)              begin idx = T_SW; fmt = FMT_S; end
                else if (f3 == F3_B)         begin idx = T_SB; fmt = FMT_S; end
                else if (RV64 && f3 == F3_D) begin idx = T_SD; fmt = FMT_S; end
            end
            OP_IMM: begin
                if (f3 == F3_ADD)       begin idx = T_ADDI;  fmt = FMT_I; end
                else if (f3 == F3_SLT)  begin idx = T_SLTI;  fmt = FMT_I; end
                else if (f3 == F3_SLTU) begin idx = T_SLTIU; fmt = FMT_I; end
            end
            OP_IMM32: begin
                if (RV64 && f3 == F3_ADD) begin idx = T_ADDIW; fmt = FMT_I; end
            end
            OP_REG: begin
                if (f7 == F7_BASE) begin
                    case (f3)
                        F3_ADD:  begin idx = T_ADD;  fmt = FMT_R; end
                        F3_SLT:  begin idx = T_SLT;  fmt = FMT_R; end
                        F3_SLTU: begin idx = T_SLTU; fmt = FMT_R; end
                        F3_XOR:  begin idx = T_XOR;  fmt = FMT_R; end
                        default: ;
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                    idx = T_SUB;
                    fmt = FMT_R;
                end
            end
            OP_REG32: begin
                if (RV64 && f3 == F3_ADD) begin
                    if (f7 == F7_BASE)     begin idx = T_ADDW; fmt = FMT_R; end
                    else if (f7 == F7_ALT) begin idx = T_SUBW; fmt = FMT_R; end
                end
            end
            OP_SYSTEM: begin
                if (inst_i == INST_EBREAK) begin idx = T_EBREAK; fmt = FMT_N; end
            end
            default: ;
        endcase
    end

    assign use_f = fmt_use(fmt);

    // A register index outside the implemented file makes the instruction illegal.
    assign bad_reg = (use_f.rs1 && (int'(rs1_f) >= NR_REG))
                   | (use_f.rs2 && (int'(rs2_f) >= NR_REG))
                   | (use_f.rd  && (int'(rd_f)  >= NR_REG));
    assign illegal = (idx == T_ILLEGAL) | bad_reg;

    assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u = {inst_i[31:12], 12'b0};
    assign imm_j = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    // Pick the 32-bit immediate for the decoded format
    always_comb begin
        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = imm_i;
            FMT_S:   imm32 = imm_s;
            FMT_B:   imm32 = imm_b;
            FMT_U:   imm32 = imm_u;
            FMT_J:   imm32 = imm_j;
            default: imm32 = '0;
        endcase
    end

    // Kept as a separate signed cast so the sign extension is not lost in a mixed-sign ternary.
    assign imm_sx    = XLEN'($signed(imm32));
    assign imm_o     = illegal ? '0 : imm_sx;
    assign type_o    = illegal ? (TYPE_W'(1) << T_ILLEGAL) : (TYPE_W'(1) << idx);
    assign use_rs1_o = !illegal && use_f.rs1;
    assign use_rs2_o = !illegal && use_f.rs2;
    assign rd_wen_o  = !illegal && use_f.rd && (rd_f != 5'd0);
    assign rs1_o     = rs1_f[AW-1:0];
    assign rs2_o     = rs2_f[AW-1:0];
    assign rd_o      = rd_wen_o ? rd_f[AW-1:0] : '0;
    assign illegal_o = illegal;

endmodule

// File: rtl/ysyx_25020047_idu_pipe.sv
// Pipelined decode stage: decoder, GPR file with write-back bypass,
// per-register busy scoreboard, and a registered valid/ready output stage.
module ysyx_25020047_idu_pipe
    import ysyx_25020047_idu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NR_REG = 32,
    localparam int AW    = $clog2(NR_REG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TYPE_W-1:0] out_type,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [AW-1:0]     out_rd,
    output logic              out_rd_wen,
    output logic [XLEN-1:0]   out_pc,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush
);

    logic [TYPE_W-1:0] dec_type;
    logic [XLEN-1:0]   dec_imm;
    logic [AW-1:0]     dec_rs1;
    logic [AW-1:0]     dec_rs2;
    logic [AW-1:0]     dec_rd;
    logic              dec_use_rs1;
    logic              dec_use_rs2;
    logic              dec_rd_wen;
    logic              dec_illegal;

    logic [XLEN-1:0]   gpr_q [NR_REG];
    logic [NR_REG-1:0] sb_q;
    logic [NR_REG-1:0] sb_d;
    logic              valid_q;
    logic              valid_d;
    logic [TYPE_W-1:0] type_q;
    logic [XLEN-1:0]   imm_q;
    logic [XLEN-1:0]   rs1_val_q;
    logic [XLEN-1:0]   rs2_val_q;
    logic [AW-1:0]     rd_q;
    logic              rd_wen_q;
    logic [XLEN-1:0]   pc_q;

    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic              haz_rs1;
    logic              haz_rs2;
    logic              haz_rd;
    logic              hazard;
    logic              fire_in;

    ysyx_25020047_idu_dec #(
        .XLEN   (XLEN),
        .NR_REG (NR_REG)
    ) u_dec (
        .inst_i    (in_inst),
        .type_o    (dec_type),
        .imm_o     (dec_imm),
        .rs1_o     (dec_rs1),
        .rs2_o     (dec_rs2),
        .rd_o      (dec_rd),
        .use_rs1_o (dec_use_rs1),
        .use_rs2_o (dec_use_rs2),
        .rd_wen_o  (dec_rd_wen),
        .illegal_o (dec_illegal)
    );

    // Operand read: unused or x0 operands are 0, a same-cycle write-back wins over the array
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (dec_use_rs1 && dec_rs1 != '0) begin
            rs1_val = (wb_valid && wb_rd == dec_rs1) ? wb_data : gpr_q[dec_rs1];
        end
        if (dec_use_rs2 && dec_rs2 != '0) begin
            rs2_val = (wb_valid && wb_rd == dec_rs2) ? wb_data : gpr_q[dec_rs2];
        end
    end

    // A busy register stalls issue unless its write-back lands this very cycle.
    assign haz_rs1  = dec_use_rs1 && sb_q[dec_rs1] && !(wb_valid && wb_rd == dec_rs1);
    assign haz_rs2  = dec_use_rs2 && sb_q[dec_rs2] && !(wb_valid && wb_rd == dec_rs2);
    assign haz_rd   = dec_rd_wen  && sb_q[dec_rd]  && !(wb_valid && wb_rd == dec_rd);
    assign hazard   = !dec_illegal && (haz_rs1 || haz_rs2 || haz_rd);

    assign in_ready = rst && (!valid_q || out_ready) && !hazard && !flush;
    assign fire_in  = in_valid && in_ready;

    // Scoreboard: write-back and flush clear, a new issue sets; the set is applied last so it wins
    always_comb begin
        sb_d = sb_q;
        if (wb_valid) begin
            sb_d[wb_rd] = 1'b0;
        end
        if (flush && valid_q && rd_wen_q) begin
            sb_d[rd_q] = 1'b0;
        end
        if (fire_in && dec_rd_wen) begin
            sb_d[dec_rd] = 1'b1;
        end
    end

    // Output-stage occupancy: a new issue refills, otherwise flush or consumption empties
    always_comb begin
        valid_d = valid_q;
        if (fire_in) begin
            valid_d = 1'b1;
        end else if (flush || out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output register: payload only moves on issue, so it holds steady during a stall
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
        if (!rst) begin
            valid_q   <= 1'b0;
            type_q    <= '0;
            imm_q     <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            rd_q      <= '0;
            rd_wen_q  <= 1'b0;
            pc_q      <= '0;
        end else begin
            valid_q <= valid_d;
            if (fire_in) begin
                type_q    <= dec_type;
                imm_q     <= dec_imm;
                rs1_val_q <= rs1_val;
                rs2_val_q <= rs2_val;
                rd_q      <= dec_rd;
                rd_wen_q  <= dec_rd_wen;
                pc_q      <= in_pc;
            end
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    // GPR file: write-back at the clock edge, x0 is never written
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the GPR array is reset like ordinary state rather than left as uninitialised memory, because operands must read 0 after reset.
        if (!rst) begin
            for (int i = 0; i < NR_REG; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (wb_valid && wb_rd != '0) begin
            gpr_q[wb_rd] <= wb_data;
        end
    end

    assign out_valid   = valid_q;
    assign out_type    = type_q;
    assign out_imm     = imm_q;
    assign out_rs1_val = rs1_val_q;
    assign out_rs2_val = rs2_val_q;
    assign out_rd      = rd_q;
    assign out_rd_wen  = rd_wen_q;
    assign out_pc      = pc_q;

endmodule
